alu_issue_ctrl: RTL and testbench

//   Initiator side of the 4-bit ALU interface: accepts instructions over valid/ready,

---
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 4-bit ALU: instruction accept, operand fetch, ALU drive,
// write-back and result handshake. Define ALU_OVF_CHECK_EN to build the res_ovf flag logic.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned REG_N  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_ld,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_ra,
  input  logic [ADDR_W-1:0] instr_rb,
  input  logic [DATA_W-1:0] instr_imm,
  output logic              alu_m,
  output logic              alu_s1,
  output logic              alu_s0,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_rd,
  output logic              res_zero,
  output logic              res_ovf
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_q;
  logic                instr_ready_q;
  logic                res_valid_q;
  logic                ld_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   imm_q;
  logic                alu_m_q, alu_s1_q, alu_s0_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q;
  logic [DATA_W-1:0]   res_data_q;
  logic [ADDR_W-1:0]   res_rd_q;
  logic                res_zero_q;
  logic [DATA_W-1:0]   rf_q [REG_N];
  logic [DATA_W-1:0]   result_d;

  always_comb begin
    result_d = ld_q ? imm_q : alu_out;
  end

`ifdef ALU_OVF_CHECK_EN
  logic              res_ovf_q;
  logic              ovf_d;
  logic [DATA_W:0]   sum_w;

  // Flag is derived from the operands already driven to the ALU, not from alu_out.
  always_comb begin
    sum_w = {1'b0, alu_a_q} + {1'b0, alu_b_q};
    ovf_d = 1'b0;
    if (!ld_q && alu_m_q) begin
      case ({alu_s1_q, alu_s0_q})
        2'b00:   ovf_d = (alu_a_q == '0);
        2'b01:   ovf_d = sum_w[DATA_W];
        2'b10:   ovf_d = (alu_a_q < alu_b_q);
        default: ovf_d = (alu_a_q == '1);
      endcase
    end
  end

  assign res_ovf = res_ovf_q;
`else
  assign res_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      instr_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      ld_q          <= 1'b0;
      rd_q          <= '0;
      imm_q         <= '0;
      alu_m_q       <= 1'b0;
      alu_s1_q      <= 1'b0;
      alu_s0_q      <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      res_data_q    <= '0;
      res_rd_q      <= '0;
      res_zero_q    <= 1'b0;
`ifdef ALU_OVF_CHECK_EN
      res_ovf_q     <= 1'b0;
`endif
      for (int unsigned i = 0; i < REG_N; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            ld_q          <= instr_ld;
            rd_q          <= instr_rd;
            imm_q         <= instr_imm;
            instr_ready_q <= 1'b0;
            state_q       <= ISSUE;
            // Loads leave the ALU inputs at their last issued values.
            if (!instr_ld) begin
              {alu_m_q, alu_s1_q, alu_s0_q} <= instr_op;
              alu_a_q <= rf_q[instr_ra];
              alu_b_q <= rf_q[instr_rb];
            end
          end
        end
        ISSUE: begin
          rf_q[rd_q]  <= result_d;
          res_data_q  <= result_d;
          res_rd_q    <= rd_q;
          res_zero_q  <= (result_d == '0);
`ifdef ALU_OVF_CHECK_EN
          res_ovf_q   <= ovf_d;
`endif
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid_q   <= 1'b0;
            instr_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q       <= IDLE;
          instr_ready_q <= 1'b1;
          res_valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = instr_ready_q;
  assign res_valid   = res_valid_q;
  assign alu_m       = alu_m_q;
  assign alu_s1      = alu_s1_q;
  assign alu_s0      = alu_s0_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign res_zero    = res_zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU and register-file model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_ready, instr_ld;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_ra, instr_rb;
  logic [3:0] instr_imm;
  logic       alu_m, alu_s1, alu_s0;
  logic [3:0] alu_a, alu_b, alu_out;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic [1:0] res_rd;
  logic       res_zero, res_ovf;

  alu_issue_ctrl #(.DATA_W(4), .REG_N(4), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_ld(instr_ld),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_imm(instr_imm),
    .alu_m(alu_m), .alu_s1(alu_s1), .alu_s0(alu_s0), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .res_zero(res_zero), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int rd;
    int zero;
    int ovf;
  } exp_t;

  exp_t expq[$];
  int   accq[$];
  int   rf[4];
  int   last_op, last_a, last_b;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rr_mode = 2;
  int   aluv;

  // Full-precision ALU result; the caller truncates to 4 bits.
  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0: return (~a) & 15;
      1: return a & b;
      2: return a ^ b;
      3: return a | b;
      4: return a - 1;
      5: return a + b;
      6: return a - b;
      default: return a + 1;
    endcase
  endfunction

  always_comb begin
    aluv = ref_alu(int'({alu_m, alu_s1, alu_s0}), int'(alu_a), int'(alu_b));
    alu_out = aluv[3:0];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (rr_mode)
      0:       res_ready = ($urandom_range(0, 3) != 0);
      1:       res_ready = 1'b0;
      default: res_ready = 1'b1;
    endcase
  end

  // Monitor: latency on rising res_valid, stability under backpressure, data on handshake.
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [3:0] prev_d = '0;
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (res_valid && !prev_v) begin
        if (accq.size() == 0) chk("spurious_res_valid", int'(res_valid), 0);
        else begin
          a = accq.pop_front();
          chk("latency", cyc - a, 1);
        end
      end
      if (res_valid && prev_v && !prev_r) chk("hold_data", int'(res_data), int'(prev_d));
      if (res_valid && res_ready) begin
        if (expq.size() == 0) chk("unexpected_result", int'(res_valid), 0);
        else begin
          e = expq.pop_front();
          chk("res_data", int'(res_data), e.data);
          chk("res_rd",   int'(res_rd),   e.rd);
          chk("res_zero", int'(res_zero), e.zero);
          chk("res_ovf",  int'(res_ovf),  e.ovf);
        end
      end
      prev_v = res_valid;
      prev_r = res_ready;
      prev_d = res_data;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 4; i++) rf[i] = 0;
    last_op = 0; last_a = 0; last_b = 0;
    expq.delete();
    accq.delete();
  endtask

  task automatic issue(input bit ld, input int op, input int rd, input int ra,
                       input int rb, input int imm, input bit abort);
    int   a, b, r, n;
    exp_t e;
    @(negedge clk);
    instr_ld = ld; instr_op = op[2:0]; instr_rd = rd[1:0]; instr_ra = ra[1:0];
    instr_rb = rb[1:0]; instr_imm = imm[3:0]; instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", int'(instr_ready), 1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    a = rf[ra]; b = rf[rb];
    if (!ld) begin
      last_op = op; last_a = a; last_b = b;
    end
    chk("alu_op", int'({alu_m, alu_s1, alu_s0}), last_op);
    chk("alu_a",  int'(alu_a), last_a);
    chk("alu_b",  int'(alu_b), last_b);
    if (!abort) begin
      r = ld ? imm : ref_alu(op, a, b);
      e.data = r & 15;
      e.rd   = rd;
      e.zero = (e.data == 0) ? 1 : 0;
`ifdef ALU_OVF_CHECK_EN
      e.ovf  = (!ld && op >= 4 && (r < 0 || r > 15)) ? 1 : 0;
`else
      e.ovf  = 0;
`endif
      rf[rd] = e.data;
      expq.push_back(e);
      accq.push_back(cyc);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || res_valid || !instr_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", expq.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_instr_ready", int'(instr_ready), 1);
    chk("rst_res_valid",   int'(res_valid), 0);
    chk("rst_res_fields",  int'({res_data, res_rd, res_zero, res_ovf}), 0);
    chk("rst_alu_fields",  int'({alu_m, alu_s1, alu_s0, alu_a, alu_b}), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
  endtask

  task automatic readback_all();
    for (int i = 0; i < 4; i++) issue(0, 3, i, i, i, 0, 0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_ld = 1'b0; instr_op = '0;
    instr_rd = '0; instr_ra = '0; instr_rb = '0; instr_imm = '0; res_ready = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();

    // Add: 9 + 3
    issue(1, 0, 1, 0, 0, 9, 0);
    issue(1, 0, 2, 0, 0, 3, 0);
    issue(0, 5, 0, 1, 2, 0, 0);
    drain();

    // Wrap-around at both ends
    issue(1, 0, 1, 0, 0, 15, 0);
    issue(0, 7, 3, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0);
    issue(0, 4, 2, 0, 0, 0, 0);
    issue(0, 6, 1, 0, 1, 0, 0);
    drain();

    // Logic ops with destination == source
    issue(1, 0, 1, 0, 0, 10, 0);
    issue(1, 0, 2, 0, 0, 6, 0);
    issue(0, 2, 1, 1, 2, 0, 0);
    issue(0, 0, 0, 1, 0, 0, 0);
    drain();

    // Backpressure with a competing instruction offered
    rr_mode = 1;
    issue(0, 5, 3, 1, 2, 0, 0);
    repeat (2) @(negedge clk);
    instr_ld = 1'b1; instr_rd = 2'd0; instr_imm = 4'd7; instr_valid = 1'b1;
    repeat (5) begin
      chk("bp_res_valid",   int'(res_valid), 1);
      chk("bp_instr_ready", int'(instr_ready), 0);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    rr_mode = 2;
    repeat (2) @(negedge clk);
    chk("bp_release_valid", int'(res_valid), 0);
    chk("bp_release_ready", int'(instr_ready), 1);
    drain();

    // Mid-run reset clears the register file
    issue(1, 0, 0, 0, 0, 5, 0);
    issue(1, 0, 3, 0, 0, 12, 0);
    drain();
    do_reset();
    readback_all();

    // Reset while an add is in ISSUE
    issue(1, 0, 1, 0, 0, 5, 0);
    issue(1, 0, 2, 0, 0, 3, 0);
    drain();
    issue(0, 5, 0, 1, 2, 0, 1);
    rst_n = 1'b0;
    clear_model();
    #4;
    chk("abort_res_valid", int'(res_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_result", int'(res_valid), 0);
    end
    issue(0, 3, 0, 1, 2, 0, 0);
    drain();
    readback_all();

    // Randomized traffic with random result backpressure
    rr_mode = 0;
    for (int i = 0; i < 60; i++) begin
      issue(($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15), 0);
    end
    rr_mode = 2;
    drain();
    readback_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
